// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, default bit
// timing and data width.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 868;
  localparam int unsigned DATA_W           = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    BRK_WAIT = 3'd4
  } rx_state_e;

  // Counter preload that lands the first sample in the middle of the start bit
  // (floored half for odd bit lengths).
  function automatic int unsigned half_bit_load(input int unsigned clks_per_bit);
    return (clks_per_bit / 2) - 1;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-stage synchroniser for an asynchronous, idle-high serial line.
// Flops preset to 1 so reset never looks like a start bit.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  // Shift the raw line through the synchroniser chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: mid-bit sampling, false-start rejection, break and
// framing-error detection. Byte and status pulses are registered.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | line idle, waiting for a low level with rx enabled
// START    | counting to mid start bit to confirm it is not a glitch
// DATA     | sampling 8 data bits LSB-first at mid-bit
// STOP     | counting to mid stop bit; decides valid / break / error
// BRK_WAIT | line still low after break or framing error; wait for high
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  input  logic       uart_rx_en,
  output logic       uart_rx_valid,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_break,
  output logic       uart_rx_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(half_bit_load(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic rxs;

  rx_state_e   state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [2:0]  idx_q, idx_nx;
  logic [DATA_W-1:0] sh_q, sh_nx;
  logic [DATA_W-1:0] data_q, data_nx;
  logic        valid_q, valid_nx;
  logic        brk_q, brk_nx;
  logic        ferr_q, ferr_nx;
  logic        armed_q, armed_nx;
  logic        tc;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rxd),
    .q   (rxs)
  );

  assign tc = (cnt_q == '0);

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      brk_q   <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      idx_q   <= idx_nx;
      sh_q    <= sh_nx;
      data_q  <= data_nx;
      valid_q <= valid_nx;
      brk_q   <= brk_nx;
      ferr_q  <= ferr_nx;
      armed_q <= armed_nx;
    end
  end

  // Next-state, counter reloads and pulse generation.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = tc ? cnt_q : cnt_q - 1'b1;
    idx_nx   = idx_q;
    sh_nx    = sh_q;
    data_nx  = data_q;
    valid_nx = 1'b0;
    brk_nx   = 1'b0;
    ferr_nx  = 1'b0;
    // A start is only trusted once the line has been seen high after reset.
    armed_nx = armed_q | rxs;

    case (state_q)
      IDLE: begin
        if (!rxs && uart_rx_en && armed_q) begin
          cnt_nx   = HALF_LOAD;
          state_nx = START;
        end
      end
      START: begin
        if (tc) begin
          if (rxs) begin
            state_nx = IDLE;
          end else begin
            cnt_nx   = FULL_LOAD;
            idx_nx   = '0;
            state_nx = DATA;
          end
        end
      end
      DATA: begin
        if (tc) begin
          sh_nx  = {rxs, sh_q[DATA_W-1:1]};
          cnt_nx = FULL_LOAD;
          idx_nx = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_nx = STOP;
          end
        end
      end
      STOP: begin
        if (tc) begin
          if (rxs) begin
            data_nx  = sh_q;
            valid_nx = 1'b1;
            state_nx = IDLE;
          end else if (sh_q == '0) begin
            brk_nx   = 1'b1;
            state_nx = BRK_WAIT;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = BRK_WAIT;
          end
        end
      end
      BRK_WAIT: begin
        if (rxs) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign uart_rx_valid     = valid_q;
  assign uart_rx_data      = data_q;
  assign uart_rx_break     = brk_q;
  assign uart_rx_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer. Each stimulus announces the outcome it
// should produce (kind, byte, start time); a compare process matches every
// DUT pulse against that queue and tracks the byte the output must hold.
module tb_uart_rx_deframer;

  localparam int CPB = 16;
  localparam int LAT = 2 + (19 * CPB) / 2 + 1;  // sync + 9.5 bits + output reg

  localparam int K_VALID = 0;
  localparam int K_BREAK = 1;
  localparam int K_FERR  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       uart_rx_en = 1'b1;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_break;
  logic       uart_rx_frame_err;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         t0;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] model_data = 8'h00;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  int         n_valid = 0;
  int         n_brk = 0;
  int         n_ferr = 0;
  int         last_lat = -1;
  int         obs_kind;
  exp_t       head;

  uart_rx_deframer #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .uart_rxd          (uart_rxd),
    .uart_rx_en        (uart_rx_en),
    .uart_rx_valid     (uart_rx_valid),
    .uart_rx_data      (uart_rx_data),
    .uart_rx_break     (uart_rx_break),
    .uart_rx_frame_err (uart_rx_frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests = tests + 1;
    if (act !== req) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare every cycle, on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("reset_outputs", {uart_rx_valid, uart_rx_break, uart_rx_frame_err, uart_rx_data}, 32'h0);
      model_data = 8'h00;
    end else begin
      if (uart_rx_valid || uart_rx_break || uart_rx_frame_err) begin
        check("pulse_one_hot", 32'(uart_rx_valid) + 32'(uart_rx_break) + 32'(uart_rx_frame_err), 32'd1);
        obs_kind = uart_rx_valid ? K_VALID : (uart_rx_break ? K_BREAK : K_FERR);
        if (uart_rx_valid) n_valid = n_valid + 1;
        if (uart_rx_break) n_brk = n_brk + 1;
        if (uart_rx_frame_err) n_ferr = n_ferr + 1;
        if (expq.size() == 0) begin
          check("unexpected_pulse", {29'd0, uart_rx_valid, uart_rx_break, uart_rx_frame_err}, 32'd0);
        end else begin
          head = expq.pop_front();
          check("pulse_kind", obs_kind, head.kind);
          last_lat = cyc - head.t0;
          check("pulse_latency", last_lat, LAT);
          if (uart_rx_valid) model_data = head.data;
        end
      end
      check("data_hold", {24'd0, uart_rx_data}, {24'd0, model_data});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_event(input int kind, input logic [7:0] b);
    exp_t e;
    e.kind = kind;
    e.data = b;
    e.t0   = cyc;
    expq.push_back(e);
  endtask

  // One 8N1 frame; drop_at_bit >= 0 lowers uart_rx_en before that data bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int drop_at_bit);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == drop_at_bit) uart_rx_en = 1'b0;
      uart_rxd = b[i];
      tick(CPB);
    end
    uart_rxd = stop_bit;
    tick(CPB);
    uart_rxd = 1'b1;
  endtask

  initial begin
    tick(3);
    rst = 1'b1;
    tick(20);
    check("post_reset_data", {24'd0, uart_rx_data}, 32'h0);

    // Plain frame
    expect_event(K_VALID, 8'hA5);
    send_byte(8'hA5, 1'b1, -1);
    tick(2 * CPB);
    check("a5_data", {24'd0, uart_rx_data}, 32'hA5);
    check("a5_latency", last_lat, 32'd155);

    // Back-to-back frames, second start right after first stop bit
    expect_event(K_VALID, 8'h01);
    send_byte(8'h01, 1'b1, -1);
    expect_event(K_VALID, 8'h3C);
    send_byte(8'h3C, 1'b1, -1);
    tick(2 * CPB);
    check("b2b_data", {24'd0, uart_rx_data}, 32'h3C);
    check("b2b_count", n_valid, 32'd3);

    // Short glitch is rejected, next frame still works
    uart_rxd = 1'b0;
    tick(5);
    uart_rxd = 1'b1;
    tick(3 * CPB);
    check("glitch_no_valid", n_valid, 32'd3);
    expect_event(K_VALID, 8'h55);
    send_byte(8'h55, 1'b1, -1);
    tick(2 * CPB);
    check("after_glitch_data", {24'd0, uart_rx_data}, 32'h55);

    // Break: line low for 12 bit times
    expect_event(K_BREAK, 8'h00);
    uart_rxd = 1'b0;
    tick(12 * CPB);
    uart_rxd = 1'b1;
    tick(3 * CPB);
    check("break_count", n_brk, 32'd1);
    check("break_no_valid", n_valid, 32'd4);
    check("break_data_kept", {24'd0, uart_rx_data}, 32'h55);
    expect_event(K_VALID, 8'h7E);
    send_byte(8'h7E, 1'b1, -1);
    tick(2 * CPB);
    check("after_break_data", {24'd0, uart_rx_data}, 32'h7E);

    // Framing error: stop bit low with nonzero data
    expect_event(K_FERR, 8'h12);
    send_byte(8'h12, 1'b0, -1);
    tick(2 * CPB);
    check("ferr_count", n_ferr, 32'd1);
    check("ferr_data_kept", {24'd0, uart_rx_data}, 32'h7E);

    // Receive disabled at start edge
    uart_rx_en = 1'b0;
    send_byte(8'h99, 1'b1, -1);
    tick(CPB);
    uart_rx_en = 1'b1;
    tick(2 * CPB);
    check("disabled_no_valid", n_valid, 32'd5);

    // Enable dropped mid-frame: byte still delivered
    expect_event(K_VALID, 8'h42);
    send_byte(8'h42, 1'b1, 3);
    tick(2 * CPB);
    uart_rx_en = 1'b1;
    check("en_drop_data", {24'd0, uart_rx_data}, 32'h42);
    check("en_drop_count", n_valid, 32'd6);

    // Reset mid-frame of 0xC3
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = (8'hC3 >> i) & 8'h01;
      tick(CPB);
    end
    rst = 1'b0;
    #1;
    check("rst_async_data", {24'd0, uart_rx_data}, 32'h0);
    check("rst_async_pulses", {29'd0, uart_rx_valid, uart_rx_break, uart_rx_frame_err}, 32'h0);
    tick(2);
    uart_rxd = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(12 * CPB);
    check("rst_no_pulse_valid", n_valid, 32'd6);
    check("rst_no_pulse_brk", n_brk, 32'd1);
    check("rst_no_pulse_ferr", n_ferr, 32'd1);

    begin
      int w;
      w = 0;
      while (expq.size() != 0 && w < 1000) begin
        tick(1);
        w = w + 1;
      end
    end
    check("expected_events_drained", expq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
